// File: rtl/ram_bist_ctrl.sv
// Port-A BIST sequencer for the on-chip RAM: fills every address with a seeded
// pattern, reads it all back through a latency-matched tag pipeline and reports.
module ram_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_seed,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [DATA_W-1:0] o_dina,
  input  logic [DATA_W-1:0] i_douta,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W:0]   o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_t                        state, state_nxt;
  logic [ADDR_W-1:0]             addr, addr_nxt;
  logic [DATA_W-1:0]             seed_q, seed_nxt;
  logic [1:0]                    dcnt, dcnt_nxt;
  logic                          start_acc;
  logic [RD_LAT:1]               vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0]   tag_pipe;
  logic [ADDR_W:0]               err_cnt, err_nxt;
  logic [ADDR_W-1:0]             first_err, first_nxt;
  logic                          pass_q, pass_nxt;
  logic                          mism;

  // Upper bits carry the low bits of ~a (zero-filled), lower bits carry a.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] s);
    logic [ADDR_W-1:0] na;
    na = ~a;
    return s ^ ((DATA_W'(na) << ADDR_W) | DATA_W'(a));
  endfunction

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    dcnt_nxt  = dcnt;
    start_acc = 1'b0;
    unique case (state)
      S_IDLE: if (i_start) begin
        start_acc = 1'b1;
        state_nxt = S_WRITE;
        addr_nxt  = '0;
      end
      S_WRITE: begin
        addr_nxt = addr + 1'b1;
        if (addr == ADDR_MAX) state_nxt = S_READ;
      end
      S_READ: begin
        addr_nxt = addr + 1'b1;
        if (addr == ADDR_MAX) begin
          state_nxt = S_DRAIN;
          dcnt_nxt  = '0;
        end
      end
      S_DRAIN: begin
        if (dcnt == DRAIN_LAST) state_nxt = S_DONE;
        else                    dcnt_nxt  = dcnt + 2'd1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign seed_nxt = start_acc ? i_seed : seed_q;

  // The tag leaving the last stage lines up with the douta of that read.
  assign mism = vld_pipe[RD_LAT] && (i_douta != pat(tag_pipe[RD_LAT], seed_q));

  always_comb begin
    err_nxt   = err_cnt;
    first_nxt = first_err;
    pass_nxt  = pass_q;
    if (start_acc) begin
      err_nxt   = '0;
      first_nxt = '0;
      pass_nxt  = 1'b0;
    end else begin
      if (mism) begin
        if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
        if (err_cnt == '0) first_nxt = tag_pipe[RD_LAT];
      end
      // Final compare lands on the same edge that enters DONE, so use err_nxt.
      if (state_nxt == S_DONE) pass_nxt = (err_nxt == '0);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      seed_q    <= '0;
      dcnt      <= '0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      pass_q    <= 1'b0;
      o_ena     <= 1'b0;
      o_wea     <= 1'b0;
      o_dina    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      seed_q    <= seed_nxt;
      dcnt      <= dcnt_nxt;
      vld_pipe[1] <= (state == S_READ);
      tag_pipe[1] <= addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      err_cnt   <= err_nxt;
      first_err <= first_nxt;
      pass_q    <= pass_nxt;
      o_ena     <= (state_nxt == S_WRITE) || (state_nxt == S_READ);
      o_wea     <= (state_nxt == S_WRITE);
      o_dina    <= (state_nxt == S_WRITE) ? pat(addr_nxt, seed_nxt) : '0;
      o_busy    <= (state_nxt != S_IDLE);
      o_done    <= (state_nxt == S_DONE);
    end
  end

  assign o_addra          = addr;
  assign o_pass           = pass_q;
  assign o_err_cnt        = err_cnt;
  assign o_first_err_addr = first_err;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with fault injection, a cycle-phase
// reference model checked every cycle, and literal pins on key results.
module tb_ram_bist_ctrl;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] seed, dina, douta;
  logic        ena, wea, busy, done, pass;
  logic [7:0]  addra, first_err;
  logic [8:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  ram_bist_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(L)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_seed(seed),
    .o_ena(ena), .o_wea(wea), .o_addra(addra), .o_dina(dina), .i_douta(douta),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
    .o_first_err_addr(first_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] tpat(input int a, input logic [15:0] s);
    logic [7:0] av;
    av = a[7:0];
    return s ^ {~av, av};
  endfunction

  // ---------------- RAM model with selectable latency and faults
  int          ram_lat = L;
  int          fmode = 0;
  logic [7:0]  fa = '0;
  logic [15:0] fb = '0;
  logic [15:0] mem [256];
  logic [15:0] rd_pipe [3];

  function automatic logic [15:0] fault(input logic [7:0] a, input logic [15:0] d);
    case (fmode)
      1:       return (a == 8'h40 || a == 8'h80) ? (d | 16'h0008) : d;
      2:       return 16'hFFFF;
      3:       return (a == fa) ? (d ^ fb) : d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dina;
    rd_pipe[0] <= fault(addra, mem[addra]);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign douta = rd_pipe[ram_lat-1];

  // ---------------- reference model: k = cycle index within a run (0 = idle)
  int          k = 0;
  bit          armed = 0;
  logic [15:0] sd = '0;
  logic [8:0]  e_err = '0;
  logic [7:0]  e_first = '0;
  logic        e_pass = 1'b0;
  logic [15:0] cap5 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      k <= 0; e_err <= '0; e_first <= '0; e_pass <= 1'b0; armed <= 1'b1;
    end else if (k == 0) begin
      if (start) begin
        k <= 1; sd <= seed; e_err <= '0; e_first <= '0; e_pass <= 1'b0;
      end
    end else begin
      // read of address a is issued in cycle 257+a and judged L cycles later
      if (k >= 257 + L && k <= 512 + L && douta != tpat(k - 257 - L, sd)) begin
        if (e_err != '1) e_err <= e_err + 1'b1;
        if (e_err == '0) e_first <= 8'(k - 257 - L);
      end
      if (k == 513 + L) e_pass <= (e_err == '0);
      k <= (k == 513 + L) ? 0 : k + 1;
    end
  end

  wire act_w = (k >= 1 && k <= 256);
  wire act_r = (k >= 257 && k <= 512);

  always @(negedge clk) if (armed) begin
    chk("busy", busy, k != 0);
    chk("done", done, k == 513 + L);
    chk("ena", ena, act_w || act_r);
    chk("wea", wea, act_w);
    chk("addra", addra, act_w ? k - 1 : (act_r ? k - 257 : 0));
    if (act_w || k == 0) chk("dina", dina, act_w ? tpat(k - 1, sd) : 16'h0);
    if (k == 0 || k == 513 + L) begin
      chk("err_cnt", err_cnt, e_err);
      chk("first_err", first_err, e_first);
      chk("pass", pass, (k == 0) ? e_pass : (e_err == '0));
    end
    if (k == 6) cap5 <= dina;
  end

  // ---------------- stimulus
  task automatic launch(input logic [15:0] s);
    start = 1'b1; seed = s;
    @(posedge clk); #1;
    start = 1'b0; seed = 16'($urandom);
  endtask

  // Runs up to 700 cycles from cycle 1; with b2b, returns in cycle 1 of the
  // follow-on run started the cycle after DONE.
  task automatic track(input bit glitch, input int rst_at, input bit b2b,
                       input logic [15:0] nseed, output int dc, output int nd);
    dc = -1; nd = 0;
    for (int c = 1; c <= 700; c++) begin
      start = glitch && (c == 10 || c == 300);
      if (glitch && start) seed = 16'($urandom);
      rst_n = (c != rst_at);
      if (b2b && dc > 0 && c == dc + 1) begin
        start = 1'b1; seed = nseed; ram_lat = L;
      end
      @(negedge clk);
      if (done) begin
        nd++;
        if (dc < 0) dc = c;
      end
      @(posedge clk); #1;
      if (b2b && dc > 0 && c == dc + 1) begin
        start = 1'b0;
        return;
      end
    end
    start = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, nd;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) rd_pipe[i] = '0;
    rst_n = 1'b0; start = 1'b0; seed = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;

    // clean run, seed 0, with ignored starts mid-test
    launch(16'h0000);
    track(1'b1, 0, 1'b0, 16'h0, dc, nd);
    chk("clean_done_cyc", dc, 513 + L);
    chk("clean_ndone", nd, 1);
    chk("clean_dina5", cap5, 16'hFA05);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_cnt, 0);
    chk("clean_first", first_err, 0);

    // reset mid-test aborts without done
    launch(16'($urandom));
    track(1'b0, 100, 1'b0, 16'h0, dc, nd);
    chk("abort_ndone", nd, 0);
    chk("abort_err", err_cnt, 0);

    // fresh run after abort
    launch(16'($urandom));
    track(1'b0, 0, 1'b0, 16'h0, dc, nd);
    chk("post_abort_ndone", nd, 1);
    chk("post_abort_pass", pass, 1);

    // stuck-at-1 on bit 3 at 0x40 and 0x80
    fmode = 1;
    launch(16'hA5A5);
    track(1'b0, 0, 1'b0, 16'h0, dc, nd);
    chk("stuck_pass", pass, 0);
    chk("stuck_err", err_cnt, 2);
    chk("stuck_first", first_err, 8'h40);

    // every read returns 0xFFFF
    fmode = 2;
    launch(16'h0000);
    track(1'b0, 0, 1'b0, 16'h0, dc, nd);
    chk("allfail_err", err_cnt, 256);
    chk("allfail_first", first_err, 0);
    chk("allfail_pass", pass, 0);

    // RAM slower than the controller expects, then back-to-back clean run
    fmode = 0; ram_lat = L + 1;
    launch(16'($urandom));
    track(1'b0, 0, 1'b1, 16'h1234, dc, nd);
    chk("lat_ndone", nd, 1);
    @(negedge clk);
    chk("b2b_cleared_err", err_cnt, 0);
    chk("b2b_busy", busy, 1);
    @(posedge clk); #1;
    track(1'b0, 0, 1'b0, 16'h0, dc, nd);
    chk("b2b_done_cyc", dc, 512 + L);
    chk("b2b_pass", pass, 1);

    // single random bit flip at a random address
    for (int r = 0; r < 3; r++) begin
      fmode = 3;
      fa = 8'($urandom_range(0, 255));
      fb = 16'(1) << $urandom_range(0, 15);
      launch(16'($urandom));
      track(1'b0, 0, 1'b0, 16'h0, dc, nd);
      chk("flip_err", err_cnt, 1);
      chk("flip_first", first_err, fa);
      chk("flip_pass", pass, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
